serial_operand_tx: RTL and testbench
====================================

SERIAL_OPERAND_TX -- requirements
Module: serial_operand_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 sends LSB first, 1 sends MSB first.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 SHALL have port start  input  1  request to send one operand pair; sampled only in IDLE.
REQ-006 SHALL have port xin  input  WIDTH  parallel operand X; captured on the accepted start edge.
REQ-007 SHALL have port yin  input  WIDTH  parallel operand Y; captured on the accepted start edge.
REQ-008 SHALL have port hold  input  1  stall request from the serial consumer; pauses the bit stream.
REQ-009 SHALL have port outa  output  1  registered serial bit of X.
REQ-010 SHALL have port outb  output  1  registered serial bit of Y.
REQ-011 SHALL have port valid  output  1  registered; high when outa/outb carry a new bit this cycle.
REQ-012 SHALL have port busy  output  1  registered; high in SHIFT and DONE states.
REQ-013 SHALL have port done  output  1  registered one-cycle pulse after the last bit.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered, no combinational input-to-output paths.
REQ-015 IDLE: on an edge with start=1, SHALL capture xin/yin, clear bit index to 0, go to SHIFT, set busy=1 and valid=0; otherwise stay in IDLE with all outputs 0.
REQ-016 SHIFT with index<WIDTH and hold=0 at an edge: SHALL drive outa/outb with operand bit index (LSB-first) or bit WIDTH-1-index (MSB-first), set valid=1, and increment the index.
REQ-017 SHIFT with hold=1 at an edge: SHALL set valid=0, hold outa/outb at their previous values, and leave the index unchanged; no bit is skipped or repeated as valid.
REQ-018 SHIFT with index==WIDTH and hold=0 at an edge: SHALL set valid=0, outa=outb=0, done=1, and go to DONE.
REQ-019 SHIFT with index==WIDTH and hold=1: SHALL stay in SHIFT with valid=0 and done=0 until hold drops.
REQ-020 DONE: at the next edge SHALL clear done and busy and go to IDLE; start is ignored in DONE.
REQ-021 Latency without hold: start accepted at edge T; valid bits follow edges T+1..T+WIDTH; done=1 after edge T+WIDTH+1; a new start is accepted no earlier than edge T+WIDTH+3.
REQ-022 start, xin, and yin changes while busy=1 SHALL be ignored; captured operands stay frozen until the next accepted start.
REQ-023 valid SHALL be high for exactly WIDTH cycles per transfer, independent of hold pattern.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, index=0, captured operands=0, and outa=outb=valid=busy=done=0, overriding all other inputs including mid-transfer.
REQ-025 The first edge with reset=0 SHALL behave as IDLE; start sampled at that edge SHALL be accepted.

Verification
REQ-026 WIDTH=8, LSB-first, xin=0x66, yin=0x72, start one cycle, hold=0 -> valid cycles outa=0,1,1,0,0,1,1,0 and outb=0,1,0,0,1,1,1,0; done pulse after edge T+9; busy low after T+10.
REQ-027 Same operands with hold=1 at the 3rd and 4th bit edges -> valid low for 2 cycles, bit sequence identical to REQ-026, done delayed by exactly 2 cycles.
REQ-028 MSB_FIRST=1, xin=0x81, yin=0x01 -> outa=1,0,0,0,0,0,0,1 and outb=0,0,0,0,0,0,0,1.
REQ-029 start held high with xin changed to 0xFF mid-transfer -> current stream unchanged; a second transfer starts only at the first IDLE edge and sends the then-present xin.
REQ-030 reset=1 after the 4th valid bit -> all outputs 0 on the next cycle, no done pulse; a new start after reset sends a full 8 bits.
REQ-031 Hold asserted continuously once index reaches WIDTH -> done withheld and valid=0 until hold=0, then done pulses exactly once.

Source files
------------

// File: rtl/serial_operand_tx_if.sv
// Handshake and data bundle between an operand producer and serial_operand_tx.
//   master : drives start/xin/yin/hold, observes the serial outputs
//   slave  : the transmitter; takes start/xin/yin/hold, drives outa/outb/valid/busy/done
// WIDTH must match the WIDTH of the serial_operand_tx instance bound to it.
interface serial_operand_tx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] xin;
  logic [WIDTH-1:0] yin;
  logic             hold;
  logic             outa;
  logic             outb;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output xin,
    output yin,
    output hold,
    input  outa,
    input  outb,
    input  valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  xin,
    input  yin,
    input  hold,
    output outa,
    output outb,
    output valid,
    output busy,
    output done
  );

endinterface

// File: rtl/serial_operand_tx.sv
// Parallel-to-serial transmitter for an operand pair (X, Y).
// A start seen in idle captures xin/yin; the two operands are then shifted out
// one bit per cycle on outa/outb (LSB or MSB first), qualified by valid. The
// consumer may stall the stream with hold. A one-cycle done pulse follows the
// last bit, then one cycle in the done state before idle accepts a new start.
//
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high
//   bus    : serial_operand_tx_if.slave
//            start/xin/yin/hold in; outa/outb/valid/busy/done out (all registered)
module serial_operand_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic                clk,
  input logic                reset,
  serial_operand_tx_if.slave bus
);

  // Index counts 0..WIDTH inclusive; WIDTH itself marks "all bits sent".
  localparam int unsigned IdxW = $clog2(WIDTH + 1);
  localparam int unsigned SelW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             outa_q, outa_d;
  logic             outb_q, outb_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SelW-1:0]  bit_sel;
  logic             bit_a;
  logic             bit_b;

  // Bit position selected by the current index. Only meaningful while
  // idx_q < WIDTH, which is the only case in which bit_a/bit_b are used.
  always_comb begin
    if (MSB_FIRST) begin
      bit_sel = SelW'(WIDTH - 1) - SelW'(idx_q);
    end else begin
      bit_sel = SelW'(idx_q);
    end
    bit_a = x_q[bit_sel];
    bit_b = y_q[bit_sel];
  end

  // Next-state and output logic. valid and done are pulses, so they default
  // low; everything else defaults to holding its value.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    outa_d  = outa_q;
    outb_d  = outb_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        outa_d = 1'b0;
        outb_d = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          x_d     = bus.xin;
          y_d     = bus.yin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end

      StShift: begin
        busy_d = 1'b1;
        if (bus.hold) begin
          // Stall: keep the last bit on the lines, do not advance. This also
          // covers idx == WIDTH, so done is withheld until hold drops.
          outa_d = outa_q;
          outb_d = outb_q;
        end else if (idx_q == LastIdx) begin
          outa_d  = 1'b0;
          outb_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          outa_d  = bit_a;
          outb_d  = bit_b;
          valid_d = 1'b1;
          idx_d   = idx_q + IdxW'(1);
        end
      end

      StDone: begin
        // start is deliberately ignored here; idle is the only accepting state.
        outa_d  = 1'b0;
        outb_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        outa_d  = 1'b0;
        outb_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      outa_q  <= 1'b0;
      outb_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      outa_q  <= outa_d;
      outb_q  <= outb_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.outa  = outa_q;
  assign bus.outb  = outb_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_operand_tx.sv
// Directed bench: an LSB-first and an MSB-first instance (WIDTH=8) share the
// same stimulus. Each transfer is recorded bit-by-bit in arrival order
// (first valid bit lands in bit 0) and compared with hand-computed values.
module tb_serial_operand_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic       hold;
  logic [7:0] xin;
  logic [7:0] yin;

  int n_vec;
  int n_err;

  serial_operand_tx_if #(.WIDTH(8)) if_l ();
  serial_operand_tx_if #(.WIDTH(8)) if_m ();

  assign if_l.start = start;
  assign if_l.hold  = hold;
  assign if_l.xin   = xin;
  assign if_l.yin   = yin;
  assign if_m.start = start;
  assign if_m.hold  = hold;
  assign if_m.xin   = xin;
  assign if_m.yin   = yin;

  serial_operand_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (if_l)
  );

  serial_operand_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (if_m)
  );

  // {outa, outb, valid, busy, done}
  logic [4:0] outs [2];
  assign outs[0] = {if_l.outa, if_l.outb, if_l.valid, if_l.busy, if_l.done};
  assign outs[1] = {if_m.outa, if_m.outb, if_m.valid, if_m.busy, if_m.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-DUT record of the latest transfer.
  logic [7:0] res_a     [2];
  logic [7:0] res_b     [2];
  logic [4:0] res_first [2];
  int         res_nv    [2];
  int         res_done  [2];
  int         res_idle  [2];
  int         res_ndone [2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start edge is edge 0. hmask[k] is the hold level for edge k. If chg_edge
  // is nonzero, xin/yin switch to x2/y2 just before that edge.
  task automatic xfer(input logic [7:0] x, input logic [7:0] y, input logic [31:0] hmask,
                      input bit keep_start, input int chg_edge,
                      input logic [7:0] x2, input logic [7:0] y2);
    logic prev_a [2];
    logic prev_b [2];
    for (int d = 0; d < 2; d++) begin
      res_a[d]     = '0;
      res_b[d]     = '0;
      res_nv[d]    = 0;
      res_done[d]  = -1;
      res_idle[d]  = -1;
      res_ndone[d] = 0;
    end
    xin   = x;
    yin   = y;
    start = 1'b1;
    hold  = hmask[0];
    step();
    for (int d = 0; d < 2; d++) res_first[d] = outs[d];
    if (!keep_start) start = 1'b0;
    for (int k = 1; k < 40; k++) begin
      hold = hmask[k];
      if (chg_edge == k) begin
        xin = x2;
        yin = y2;
      end
      for (int d = 0; d < 2; d++) begin
        prev_a[d] = outs[d][4];
        prev_b[d] = outs[d][3];
      end
      step();
      for (int d = 0; d < 2; d++) begin
        if (res_idle[d] < 0) begin
          if (outs[d][2]) begin
            if (res_nv[d] < 8) begin
              res_a[d][res_nv[d]] = outs[d][4];
              res_b[d][res_nv[d]] = outs[d][3];
            end
            res_nv[d]++;
          end else if (hmask[k] && res_nv[d] > 0) begin
            check($sformatf("hold_keeps_bits_dut%0d_e%0d", d, k),
                  {30'd0, outs[d][4], outs[d][3]}, {30'd0, prev_a[d], prev_b[d]});
          end
          if (outs[d][0]) begin
            res_ndone[d]++;
            if (res_done[d] < 0) res_done[d] = k;
            check($sformatf("done_lines_zero_dut%0d", d), {29'd0, outs[d][4:2]}, 32'd0);
          end
          if (!outs[d][1]) res_idle[d] = k;
        end
      end
      if (res_idle[0] >= 0 && res_idle[1] >= 0) break;
    end
  endtask

  task automatic expect_xfer(input int d, input string tag, input logic [7:0] ea,
                             input logic [7:0] eb, input int ed, input int ei);
    check($sformatf("%s_d%0d_first", tag, d), {27'd0, res_first[d]}, 32'h2);
    check($sformatf("%s_d%0d_outa", tag, d), {24'd0, res_a[d]}, {24'd0, ea});
    check($sformatf("%s_d%0d_outb", tag, d), {24'd0, res_b[d]}, {24'd0, eb});
    check($sformatf("%s_d%0d_nvalid", tag, d), res_nv[d], 32'd8);
    check($sformatf("%s_d%0d_done_edge", tag, d), res_done[d], ed);
    check($sformatf("%s_d%0d_done_count", tag, d), res_ndone[d], 32'd1);
    check($sformatf("%s_d%0d_idle_edge", tag, d), res_idle[d], ei);
  endtask

  initial begin
    int ndone;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    xin   = '0;
    yin   = '0;
    repeat (3) step();
    check("reset_outs_lsb", {27'd0, outs[0]}, 32'd0);
    check("reset_outs_msb", {27'd0, outs[1]}, 32'd0);

    // Start on the very first edge out of reset; plain LSB stream of 0x66/0x72.
    reset = 1'b0;
    xfer(8'h66, 8'h72, 32'h0, 1'b0, 0, 8'h00, 8'h00);
    expect_xfer(0, "basic", 8'h66, 8'h72, 9, 10);
    expect_xfer(1, "basic", 8'h66, 8'h4E, 9, 10);

    // Hold on the 3rd and 4th bit edges: same bits, done two cycles later.
    xfer(8'h66, 8'h72, 32'h18, 1'b0, 0, 8'h00, 8'h00);
    expect_xfer(0, "hold34", 8'h66, 8'h72, 11, 12);
    expect_xfer(1, "hold34", 8'h66, 8'h4E, 11, 12);

    // MSB-first order check: 0x81 -> 1,0,..,0,1 ; 0x01 -> 0,..,0,1.
    xfer(8'h81, 8'h01, 32'h0, 1'b0, 0, 8'h00, 8'h00);
    expect_xfer(0, "x81", 8'h81, 8'h01, 9, 10);
    expect_xfer(1, "x81", 8'h81, 8'h80, 9, 10);

    // Hold on every odd edge: valid still exactly 8 times.
    xfer(8'hB4, 8'h0F, 32'h0000_AAAA, 1'b0, 0, 8'h00, 8'h00);
    expect_xfer(0, "althold", 8'hB4, 8'h0F, 17, 18);
    expect_xfer(1, "althold", 8'h2D, 8'hF0, 17, 18);

    // start held high, operands changed mid-transfer: stream unaffected and
    // the next transfer begins on the first idle edge with the new operands.
    xfer(8'h66, 8'h72, 32'h0, 1'b1, 4, 8'hFF, 8'h00);
    expect_xfer(0, "frozen", 8'h66, 8'h72, 9, 10);
    expect_xfer(1, "frozen", 8'h66, 8'h4E, 9, 10);
    xfer(8'hFF, 8'h00, 32'h0, 1'b0, 0, 8'h00, 8'h00);
    expect_xfer(0, "restart", 8'hFF, 8'h00, 9, 10);
    expect_xfer(1, "restart", 8'hFF, 8'h00, 9, 10);

    // Hold high from the index==WIDTH edge for five cycles: done withheld.
    xfer(8'h66, 8'h72, 32'h0000_3E00, 1'b0, 0, 8'h00, 8'h00);
    expect_xfer(0, "holdend", 8'h66, 8'h72, 14, 15);
    expect_xfer(1, "holdend", 8'h66, 8'h4E, 14, 15);

    // Reset after the 4th valid bit aborts the transfer with no done pulse.
    xin   = 8'h66;
    yin   = 8'h72;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("pre_reset_valid", {31'd0, outs[0][2]}, 32'd1);
    check("pre_reset_busy", {31'd0, outs[0][1]}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_outs_lsb", {27'd0, outs[0]}, 32'd0);
    check("midreset_outs_msb", {27'd0, outs[1]}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (outs[0][0] || outs[1][0]) ndone++;
    end
    check("no_done_after_reset", ndone, 32'd0);
    check("idle_after_reset", {27'd0, outs[0]}, 32'd0);
    xfer(8'h1E, 8'h35, 32'h0, 1'b0, 0, 8'h00, 8'h00);
    expect_xfer(0, "postrst", 8'h1E, 8'h35, 9, 10);
    expect_xfer(1, "postrst", 8'h78, 8'hAC, 9, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
